sipo_capture_ctrl: RTL and testbench
====================================

# sipo_capture_ctrl

Controller that sequences a serial-in/parallel-out shift datapath to capture framed words from a serial bit stream. On a `start` command it clears the datapath, shifts in a programmed number of qualified bits, then presents the right-aligned parallel word on a valid/ready output port until it is consumed. It sits between a serial receive front end and any word-level consumer, and adds flow control and overrun detection that a bare shift chain does not provide.

## Interface
- `WIDTH`, 10: datapath and output word width in bits; must be at least 2.
- `CNT_W`, `$clog2(WIDTH+1)`: width of the length and bit-count fields.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a capture frame; sampled only in IDLE, or in HOLD during the output handshake cycle.
- `len` input CNT_W: bits per frame, sampled with `start`; 0 or any value above WIDTH means WIDTH.
- `sin` input 1: serial data bit.
- `sin_valid` input 1: `sin` is qualified this cycle.
- `out_data` output WIDTH: captured word, right-aligned; unused upper bits are 0.
- `out_valid` output 1: `out_data` holds a complete frame.
- `out_ready` input 1: consumer accepts the word.
- `busy` output 1: high in SHIFT and HOLD.
- `overrun` output 1: sticky flag; a qualified bit arrived while a word was waiting in HOLD.

## Operation
- States: IDLE, SHIFT, HOLD.
- IDLE: `start` latches the effective length into `len_q`, clears the datapath and the bit counter, clears `overrun`, and moves to SHIFT. `sin_valid` in IDLE is ignored and does not set `overrun`.
- SHIFT: each `sin_valid` cycle shifts the datapath left by one with `sin` entering at bit 0, and increments `cnt`. When the accepting cycle makes `cnt == len_q`, move to HOLD. `start` in SHIFT is ignored.
- HOLD: `out_valid` is 1 and `out_data` is stable.
  - `out_valid && out_ready`: complete the handshake and go to IDLE.
  - If `start` is also high in that cycle, go directly to SHIFT with new `len_q`, a cleared datapath and cleared `overrun`.
  - `sin_valid` without the handshake: drop the bit and set `overrun`.
  - `sin_valid` in the handshake cycle: drop the bit and do not set `overrun`.
- Bit order: the first captured bit ends at `out_data[len_q-1]` and the last at `out_data[0]`.
- Arithmetic: `cnt` is CNT_W bits wide, counts 0..len_q, and never wraps.

## Timing
- Reset values: state IDLE, `out_data` 0, `out_valid` 0, `busy` 0, `overrun` 0, `cnt` 0, `len_q` 0.
- `start` at edge k: `busy` is 1 from edge k, and the first bit can be accepted at edge k+1.
- Last qualified bit at edge m: `out_valid` and the final `out_data` are visible from edge m, so there is zero extra latency.
- Minimum frame time: len_q+1 cycles from `start` to `out_valid`.
- Back-to-back frames: a `start` in the handshake cycle gives no idle bubble.
- Reset asserted mid-frame: immediately returns all state to the reset values; any partial word is discarded.
- `out_data` changes only in SHIFT, or on the clear caused by `start`.

## Structure
- Package `sipo_capture_pkg`:
  - state enum `state_e` with values IDLE=2'd0, SHIFT=2'd1, HOLD=2'd2;
  - function `eff_len(len)` that maps 0 or values above WIDTH to WIDTH.
- Sub-module `sipo_core`: WIDTH-bit serial-in shift register with ports `clk`, `rst_n`, `clr`, `en`, `d`, `q`.
  - `clr` has priority over `en`.
  - The controller instantiates one `sipo_core` and drives `clr` and `en` from the FSM.

## Test plan
- Reset, then `start` with `len`=0 followed by 10 bits 1,0,1,1,0,0,1,0,1,1 → `out_data`=10'b1011001011 and `out_valid` high on the cycle after the last bit.
- `start` with `len`=3 and bits 1,1,0, with `out_ready` tied high → `out_data`=10'b0000000110; `out_valid` high for exactly 1 cycle, then IDLE.
- HOLD with `out_ready` low for 5 cycles while `sin_valid` pulses twice → `out_data` unchanged and `overrun`=1; the next `start` clears `overrun` to 0.
- `start` with `len`=2 asserted in the same cycle as the HOLD handshake → no idle cycle, and the new frame captures from the next cycle.
- Reset pulsed after 4 of 10 bits → all outputs 0 immediately; the later bits are ignored until `start`.
- `start` with `len`=15 and `len`=10 → both frames complete after exactly 10 bits; `start` asserted during SHIFT has no effect.

Source files
------------

// File: rtl/sipo_capture_pkg.sv
// Shared types and helpers for the serial-in/parallel-out capture controller.
package sipo_capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Effective frame length: 0 or anything longer than the datapath means a full word.
    function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
        return ((len == 0) || (len > width)) ? width : len;
    endfunction

endpackage

// File: rtl/sipo_core.sv
// WIDTH-bit serial-in shift register; new bits enter at bit 0, clear wins over shift.
module sipo_core #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    // Shift left by one on enable; synchronous clear for frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en)
            q <= {q[WIDTH-2:0], d};
    end

endmodule

// File: rtl/sipo_capture_ctrl.sv
// Frame capture controller: sequences a sipo_core through IDLE/SHIFT/HOLD and
// presents each completed word on a valid/ready port with overrun detection.
module sipo_capture_ctrl
    import sipo_capture_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun
);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] cnt, len_q, cnt_inc;
    logic             clr, en, load;

    assign cnt_inc   = cnt + CNT_W'(1);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    sipo_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (en),
        .d     (sin),
        .q     (out_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and datapath controls; a start in the HOLD handshake cycle
    // chains straight into the next frame with no idle bubble.
    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        en        = 1'b0;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    clr       = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (sin_valid) begin
                    en = 1'b1;
                    if (cnt_inc == len_q)
                        state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        load      = 1'b1;
                        clr       = 1'b1;
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame length latch and accepted-bit counter; cnt stops at len_q since
    // SHIFT is left on the bit that reaches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            cnt   <= '0;
        end else if (load) begin
            len_q <= CNT_W'(eff_len(32'(len), WIDTH));
            cnt   <= '0;
        end else if (en) begin
            cnt   <= cnt_inc;
        end
    end

    // Sticky overrun: a qualified bit dropped while the word waits unconsumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overrun <= 1'b0;
        else if (load)
            overrun <= 1'b0;
        else if ((state == HOLD) && sin_valid && !out_ready)
            overrun <= 1'b1;
    end

endmodule

// File: tb/tb_sipo_capture_ctrl.sv
// Directed bench for sipo_capture_ctrl: expected words are queued when a frame
// starts and a negedge monitor compares them at each output handshake.
module tb_sipo_capture_ctrl;

    localparam int WIDTH = 10;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             sin;
    logic             sin_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overrun;

    int               n_chk  = 0;
    int               n_pass = 0;
    logic [WIDTH-1:0] exp_q[$];

    sipo_capture_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .sin       (sin),
        .sin_valid (sin_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // Monitor: a handshake completes at the next rising edge, so compare here.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL word: got %0h expected none at %0t", out_data, $time);
            end else begin
                check("word", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start(input logic [CNT_W-1:0] l, input bit push, input logic [WIDTH-1:0] w);
        start = 1'b1;
        len   = l;
        if (push) exp_q.push_back(w);
        tick();
        start = 1'b0;
        len   = '0;
        check("busy after start", busy, 1);
    endtask

    // Bits go out MSB first from bits[n-1]; poke fires a start during SHIFT.
    task automatic send_bits(input logic [WIDTH-1:0] bits, input int n, input int poke);
        for (int i = n - 1; i >= 0; i--) begin
            sin       = bits[i];
            sin_valid = 1'b1;
            if (i == poke) begin
                start = 1'b1;
                len   = CNT_W'(2);
            end
            tick();
            start = 1'b0;
            len   = '0;
            if (i > 0) check("valid mid-frame", out_valid, 0);
        end
        sin_valid = 1'b0;
        sin       = 1'b0;
        check("valid after last bit", out_valid, 1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid after consume", out_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; len = '0; sin = 1'b0; sin_valid = 1'b0; out_ready = 1'b0;
        #12;
        check("reset out_data", 32'(out_data), 0);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset overrun", overrun, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        tick();

        // len 0 means full width
        frame_start(CNT_W'(0), 1'b1, 10'b1011001011);
        send_bits(10'b1011001011, 10, -1);
        tick();
        check("hold keeps valid", out_valid, 1);
        consume();
        check("idle after consume", busy, 0);

        // short frame with ready tied high: valid for exactly one cycle
        out_ready = 1'b1;
        frame_start(CNT_W'(3), 1'b1, 10'b0000000110);
        send_bits(10'b0000000110, 3, -1);
        tick();
        check("valid one cycle", out_valid, 0);
        check("idle after short frame", busy, 0);
        out_ready = 1'b0;

        // stall in HOLD with two dropped bits
        frame_start(CNT_W'(4), 1'b1, 10'b0000001001);
        send_bits(10'b0000001001, 4, -1);
        for (int c = 0; c < 5; c++) begin
            sin_valid = (c == 1 || c == 3);
            sin       = 1'b1;
            tick();
        end
        sin_valid = 1'b0;
        sin       = 1'b0;
        check("stalled out_data", 32'(out_data), 32'h009);
        check("overrun set", overrun, 1);
        check("stalled valid", out_valid, 1);

        // handshake + start + qualified bit in the same cycle
        out_ready = 1'b1; start = 1'b1; len = CNT_W'(2); sin_valid = 1'b1; sin = 1'b1;
        exp_q.push_back(10'b0000000010);
        tick();
        out_ready = 1'b0; start = 1'b0; len = '0; sin_valid = 1'b0; sin = 1'b0;
        check("chain busy", busy, 1);
        check("chain valid low", out_valid, 0);
        check("chain overrun cleared", overrun, 0);
        check("chain datapath cleared", 32'(out_data), 0);
        send_bits(10'b0000000010, 2, -1);
        consume();

        // reset mid-frame
        frame_start(CNT_W'(10), 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            sin       = (i != 1);
            sin_valid = 1'b1;
            tick();
        end
        #2 rst_n = 1'b0;
        #1;
        check("midreset out_data", 32'(out_data), 0);
        check("midreset busy", busy, 0);
        check("midreset valid", out_valid, 0);
        #2 rst_n = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sin = 1'b1;
            tick();
        end
        sin_valid = 1'b0;
        sin       = 1'b0;
        check("post-reset busy", busy, 0);
        check("post-reset out_data", 32'(out_data), 0);
        check("post-reset valid", out_valid, 0);

        // oversized length clamps to WIDTH; start during SHIFT is ignored
        frame_start(CNT_W'(15), 1'b1, 10'b1100110101);
        send_bits(10'b1100110101, 10, 6);
        consume();
        frame_start(CNT_W'(10), 1'b1, 10'b0111000110);
        send_bits(10'b0111000110, 10, 3);
        consume();

        tick();
        tick();
        check("scoreboard drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
